// File: rtl/instr_fetch_unit_if.sv
// Program-memory read bus between the instruction fetch unit and program memory.
//   mem_req   : read request, held until mem_ack (driven by master)
//   mem_addr  : read address, stable while mem_req=1 (driven by master)
//   mem_rdata : read data, valid when mem_ack=1 (driven by slave)
//   mem_ack   : read complete (driven by slave)
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches opcode/operand
// bytes from program memory over a req/ack bus and presents them to the
// control sequencer.
//   clk, reset      : clock, synchronous active-high reset
//   i_fetch_op      : pulse, fetch byte at PC into opcode register
//   i_fetch_arg     : pulse, fetch byte at PC into operand register
//   i_pc_load       : pulse, load PC from i_pc_load_val
//   i_pc_load_val   : new PC value
//   mem             : program-memory read bus (master side)
//   o_opcode        : last fetched opcode
//   o_operand       : last fetched operand
//   o_pc            : current program counter
//   o_busy          : fetch in progress
//   o_done          : one-cycle pulse, fetch completed
//   o_fault         : sticky, set on ack timeout
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_fetch_op,
    input  logic                  i_fetch_arg,
    input  logic                  i_pc_load,
    input  logic [ADDR_W-1:0]     i_pc_load_val,
    instr_fetch_unit_if.master    mem,
    output logic [DATA_W-1:0]     o_opcode,
    output logic [DATA_W-1:0]     o_operand,
    output logic [ADDR_W-1:0]     o_pc,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    // Counter value on the last WAIT cycle allowed before abort.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_tgt_arg;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_opcode;
    logic [DATA_W-1:0] r_operand;
    logic              r_busy;
    logic              r_done;
    logic              r_fault;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_val;

    // Pending PC load including one arriving this cycle (newest value wins).
    logic              w_load_hold;
    logic [ADDR_W-1:0] w_load_val;

    always_comb begin
        w_load_hold = i_pc_load | r_pend;
        w_load_val  = i_pc_load ? i_pc_load_val : r_pend_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tgt_arg  <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_pc       <= RESET_PC;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_fetch_op || i_fetch_arg) begin
                        r_tgt_arg <= ~i_fetch_op;
                        // A simultaneous load redirects this very fetch.
                        r_addr    <= i_pc_load ? i_pc_load_val : r_pc;
                        if (i_pc_load) begin
                            r_pc <= i_pc_load_val;
                        end
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= REQ;
                    end else if (i_pc_load) begin
                        r_pc <= i_pc_load_val;
                    end
                end
                REQ: begin
                    r_cnt      <= '0;
                    r_pend     <= w_load_hold;
                    r_pend_val <= w_load_val;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    r_pend     <= w_load_hold;
                    r_pend_val <= w_load_val;
                    if (mem.mem_ack) begin
                        if (r_tgt_arg) begin
                            r_operand <= mem.mem_rdata;
                        end else begin
                            r_opcode <= mem.mem_rdata;
                        end
                        r_pc    <= r_pc + 1'b1;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_cnt == TMO_LAST) begin
                        r_fault <= 1'b1;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                        // Aborted fetch still honours a jump issued during it.
                        if (w_load_hold) begin
                            r_pc <= w_load_val;
                        end
                        r_pend <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Pending jump overrides the post-increment.
                    if (w_load_hold) begin
                        r_pc <= w_load_val;
                    end
                    r_pend  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req  = r_req;
    assign mem.mem_addr = r_addr;
    assign o_opcode     = r_opcode;
    assign o_operand    = r_operand;
    assign o_pc         = r_pc;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_fault      = r_fault;
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the opcode interface. Fetches instruction and operand bytes from program memory over a req/ack bus, latches them, and presents them to the control sequencer.
- Owns the program counter: post-increment on every completed fetch, load on jump/call/ret.
- Sits between program memory and the control FSM. Supplies `opcode` and `operand`; receives fetch and PC-load commands.

Parameters:
- ADDR_W, 8, program counter / memory address width
- DATA_W, 8, instruction/operand byte width
- RESET_PC, 0, PC value after reset
- TIMEOUT, 15, max cycles to wait for mem_ack before abort (must fit in 4 bits)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- fetch_op  input  1  pulse: fetch byte at PC into opcode register
- fetch_arg  input  1  pulse: fetch byte at PC into operand register
- pc_load  input  1  pulse: load PC from pc_load_val
- pc_load_val  input  ADDR_W  new PC value
- mem_req  output  1  memory read request
- mem_addr  output  ADDR_W  read address, stable while mem_req=1
- mem_rdata  input  DATA_W  read data, valid when mem_ack=1
- mem_ack  input  1  memory read complete
- opcode  output  DATA_W  last fetched opcode
- operand  output  DATA_W  last fetched operand
- pc  output  ADDR_W  current program counter
- busy  output  1  fetch in progress
- done  output  1  one-cycle pulse: fetch completed
- fault  output  1  sticky; set on ack timeout

Behaviour:
- Reset values:
  - pc=RESET_PC; opcode=0; operand=0.
  - mem_req=0, busy=0, done=0, fault=0.
  - State=IDLE; pending-load flag cleared.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On fetch_op or fetch_arg: go to REQ. Record the target register (op vs arg); fetch_op wins if both are asserted.
  - On pc_load with no fetch request: pc <= pc_load_val next cycle.
  - If pc_load and a fetch request arrive together: the load applies first, and the fetch uses pc_load_val as its address.
- REQ (1 cycle):
  - mem_req=1, mem_addr=pc, busy=1, timeout counter cleared. Go to WAIT.
- WAIT:
  - mem_req held at 1 and mem_addr held stable until ack.
  - On mem_ack: capture mem_rdata into the target register, pc <= pc+1 (wraps modulo 2^ADDR_W, 0xFF→0x00), mem_req=0, go to DONE.
  - Counter increments each cycle without ack. On reaching TIMEOUT with no ack: fault <= 1, mem_req=0, go to IDLE. The target register and pc are unchanged, and done is not pulsed.
  - mem_ack in the same cycle the counter reaches TIMEOUT: the ack wins.
- DONE (1 cycle):
  - done=1, busy=0.
  - If a pending load is recorded: apply pc <= pending value, which overrides the increment.
  - Return to IDLE.
- Latency: a fetch issued at cycle N with mem_ack at the first WAIT cycle (N+2) gives done at N+3, with opcode/operand valid from N+3.
- Requests while busy:
  - fetch_op/fetch_arg while busy=1: ignored, no queueing.
  - pc_load while busy=1: the value is stored as pending, with last-writer-wins. It is applied in the DONE cycle, or on the return to IDLE after a timeout.
- mem_ack outside WAIT: ignored.
- opcode and operand hold their values until overwritten by a successful fetch.
- fault:
  - Cleared only by reset.
  - Does not block further fetches.
- Reset asserted mid-fetch: everything returns to reset values on the next edge, mem_req drops immediately, and pending is lost.

Test Plan:
- Basic fetch:
  - Stimulus: reset, RESET_PC=0, memory[0]=0x3A with 1-cycle ack, pulse fetch_op.
  - Required: mem_addr=0x00; done pulses exactly once; opcode=0x3A; pc=0x01; busy low after done.
- Opcode + operand with slow memory:
  - Stimulus: memory[1]=0x05, memory[2]=0x7F, ack delayed 3 cycles, fetch_op then fetch_arg after each done.
  - Required: opcode=0x05, operand=0x7F, pc=0x03; mem_addr stable throughout each WAIT.
- Jump during fetch:
  - Stimulus: pc_load_val=0x40 pulsed while in WAIT.
  - Required: the fetch completes from the old address; pc=0x40 after DONE, not old+1; the next fetch_op reads address 0x40.
- Simultaneous load and fetch in IDLE:
  - Stimulus: pc_load=1 with value 0x10 and fetch_op=1 in the same cycle.
  - Required: mem_addr=0x10; pc=0x11 after done.
- Wrap and timeout:
  - Stimulus: pc=0xFF, fetch_op with ack given → pc=0x00. Then fetch_op with no ack.
  - Required: fault=1 after TIMEOUT WAIT cycles; opcode unchanged; pc=0x00; no done pulse; a later fetch with ack still succeeds and fault stays 1.
- Reset mid-fetch:
  - Stimulus: assert reset in WAIT.
  - Required: next edge gives mem_req=0, pc=RESET_PC, opcode=0, fault=0; a late mem_ack is ignored.
